hc20_stream_accumulator: RTL and testbench

- Sequential wrapper that feeds a stream of 20-bit operands into one combinational 20-bit Han-Carlson adder instance and consumes its sum.
- Each cycle: accumulator register is operand A, accepted input word is operand B, adder sum is written back.
- Frames are delimited by in_last. On the last beat the frame total, an unsigned overflow flag and a beat count are presented on a valid/ready output port.
- Sits between the sample source and the downstream result consumer.

---
 rtl/hc20_stream_accumulator.sv | 178 +++++++++++++++++
 tb/tb_hc20_stream_accumulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hc20_stream_accumulator.sv
// hc20_stream_accumulator
//   Accumulates a framed stream of 20-bit words through a Han-Carlson adder.
//   At the end of each frame it presents the frame total, a sticky unsigned
//   overflow flag and a saturating beat count on a valid/ready result port.
//   Contains the adder (hc20_adder) and the wrapper (hc20_stream_accumulator).

// 20-bit Han-Carlson adder, no carry in, no carry out.
// Odd bit positions run a Kogge-Stone prefix tree; even positions are
// resolved in one extra level from their odd neighbour below.
module hc20_adder (
    input  logic [19:0] a_i,
    input  logic [19:0] b_i,
    output logic [19:0] sum_o
);
    logic [19:0] g;
    logic [19:0] p;
    logic [19:0] gg;
    logic [19:0] pp;
    logic [19:0] gn;
    logic [19:0] pn;
    logic [19:0] c;

    // prefix tree, odd-position combine levels, then even fix-up and sum
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = g;
        pp = p;
        gn = g;
        pn = p;
        c  = '0;
        for (int l = 0; l < 5; l++) begin
            gn = gg;
            pn = pp;
            for (int i = 1; i < 20; i += 2) begin
                if (i >= (1 << l)) begin
                    gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pn[i] = pp[i] & pp[i - (1 << l)];
                end
            end
            gg = gn;
            pp = pn;
        end
        // carry into bit i is the group generate of bits [i-1:0]
        for (int i = 1; i < 20; i++) begin
            if ((i - 1) % 2 == 1) begin
                c[i] = gg[i - 1];
            end else if (i == 1) begin
                c[i] = g[0];
            end else begin
                c[i] = g[i - 1] | (p[i - 1] & gg[i - 2]);
            end
        end
        sum_o = p ^ c;
    end
endmodule

module hc20_stream_accumulator #(
    // the adder instance is hard-wired to 20 bits; no other width is legal
    parameter int WIDTH = 20,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_overflow_q;
    logic [CNT_W-1:0] out_count_q;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             beat;
    logic [WIDTH-1:0] acc_d;
    logic             ovf_d;
    logic [CNT_W-1:0] cnt_d;

    // unsigned carry out of the MSB, rebuilt from operand and sum MSBs
    function automatic logic carry_out(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
        return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
    endfunction

    // beat counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hc20_adder u_adder (
        .a_i   (op_a),
        .b_i   (in_data),
        .sum_o (sum)
    );

    // first beat of a frame starts from zero so no explicit clear is needed
    always_comb begin
        op_a  = (state_q == IDLE) ? '0 : acc_q;
        beat  = in_valid & in_ready;
        carry = carry_out(op_a[WIDTH-1], in_data[WIDTH-1], sum[WIDTH-1]);
        acc_d = sum;
        if (state_q == IDLE) begin
            ovf_d = carry;
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_d = ovf_q | carry;
            cnt_d = sat_inc(cnt_q);
        end
    end

    // frame FSM: accumulate beats, capture result on the last one, hold it
    // until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_overflow_q <= 1'b0;
            out_count_q    <= '0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_d;
                        if (in_last) begin
                            state_q        <= HOLD;
                            out_valid_q    <= 1'b1;
                            out_sum_q      <= acc_d;
                            out_overflow_q <= ovf_d;
                            out_count_q    <= cnt_d;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (state_q != HOLD);
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_overflow_q;
    assign out_count    = out_count_q;
endmodule

// File: tb/tb_hc20_stream_accumulator.sv
// Bench for hc20_stream_accumulator: directed frames plus randomized frames
// checked against a frame-level arithmetic model.
module tb_hc20_stream_accumulator;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_sum;
    logic        out_overflow;
    logic [7:0]  out_count;

    int     n_chk;
    int     n_err;
    longint f_total;
    int     f_n;

    hc20_stream_accumulator #(.WIDTH(20), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        f_total = 0;
        f_n     = 0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_sum"},   32'(out_sum), 32'd0);
        check_val({tag, "_ovf"},   32'(out_overflow), 32'd0);
        check_val({tag, "_cnt"},   32'(out_count), 32'd0);
        check_val({tag, "_rdy"},   32'(in_ready), 32'd1);
    endtask

    // idle gap cycles with random noise on data/last, then one beat
    task automatic beat(input logic [19:0] d, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid  = 1'b0;
            in_data   = 20'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            check_val("gap_valid", 32'(out_valid), 32'd0);
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        out_ready = 1'($urandom);
        check_val("beat_rdy", 32'(in_ready), 32'd1);
        tick();
        f_total += longint'(d);
        f_n++;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!last) check_val("mid_valid", 32'(out_valid), 32'd0);
    endtask

    // check presented result, stall for hold cycles, then hand it off
    task automatic finish_frame(input int hold);
        logic [19:0] e_sum;
        logic        e_ovf;
        int          e_cnt;
        e_sum = 20'(f_total % 64'd1048576);
        e_ovf = (f_total >= 64'd1048576);
        e_cnt = (f_n > 255) ? 255 : f_n;
        check_val("res_valid", 32'(out_valid), 32'd1);
        check_val("res_sum",   32'(out_sum), 32'(e_sum));
        check_val("res_ovf",   32'(out_overflow), 32'(e_ovf));
        check_val("res_cnt",   32'(out_count), 32'(e_cnt));
        check_val("res_rdy",   32'(in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = 20'($urandom);
            in_last   = 1'($urandom);
            tick();
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_sum",   32'(out_sum), 32'(e_sum));
            check_val("hold_ovf",   32'(out_overflow), 32'(e_ovf));
            check_val("hold_cnt",   32'(out_count), 32'(e_cnt));
            check_val("hold_rdy",   32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'($urandom);
        in_data   = 20'($urandom);
        in_last   = 1'($urandom);
        tick();
        check_val("hs_valid", 32'(out_valid), 32'd0);
        check_val("hs_rdy",   32'(in_ready), 32'd1);
        check_val("hs_sum",   32'(out_sum), 32'(e_sum));
        check_val("hs_cnt",   32'(out_count), 32'(e_cnt));
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();
        tick();
        do_reset();
        check_reset_state("rst");

        // small frame, immediate handshake
        beat(20'h00001, 1'b0, 0);
        beat(20'h00002, 1'b0, 0);
        beat(20'h00003, 1'b1, 0);
        finish_frame(0);

        // wrap with overflow, then clean frame clears the flag
        beat(20'hFFFFF, 1'b0, 0);
        beat(20'h00001, 1'b1, 0);
        finish_frame(0);
        beat(20'h00005, 1'b1, 0);
        finish_frame(0);

        // single beat held under back-pressure for 5 cycles
        beat(20'hABCDE, 1'b1, 0);
        finish_frame(5);

        // count saturation
        for (int i = 0; i < 300; i++) beat(20'h00001, (i == 299), 0);
        finish_frame(0);

        // mid-frame reset discards partial frame
        beat(20'h00010, 1'b0, 0);
        beat(20'h00020, 1'b0, 0);
        do_reset();
        check_reset_state("abort");
        beat(20'h00007, 1'b1, 0);
        finish_frame(1);

        // valid toggling every other cycle
        beat(20'h80000, 1'b0, 1);
        beat(20'h80000, 1'b1, 1);
        finish_frame(0);

        // reset while a result is pending
        beat(20'h12345, 1'b1, 0);
        check_val("pend_valid", 32'(out_valid), 32'd1);
        do_reset();
        check_reset_state("hold_rst");

        // randomized frames, some aborted by reset
        for (int f = 0; f < 40; f++) begin
            int n;
            n = int'($urandom_range(1, 8));
            if ($urandom_range(0, 7) == 0) begin
                for (int b = 0; b < n; b++)
                    beat(20'($urandom), 1'b0, int'($urandom_range(0, 2)));
                do_reset();
                check_reset_state("rnd_abort");
            end else begin
                for (int b = 0; b < n; b++) begin
                    logic [19:0] d;
                    d = ($urandom_range(0, 2) == 0) ? (20'hF0000 | 20'($urandom))
                                                    : 20'($urandom);
                    beat(d, (b == n - 1), int'($urandom_range(0, 2)));
                end
                finish_frame(int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
